// File: rtl/mio_pkg.sv
// Shared types and constants for the MIO bus responder.
package mio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  localparam logic [27:0]  LED_OFS = 28'h000_0000;
  localparam logic [27:0]  SW_OFS  = 28'h000_0004;
  localparam int unsigned  CNT_W   = 4;

endpackage

// File: rtl/mio_ram.sv
// Synchronous single-port word RAM with write enable and registered read.
module mio_ram #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1 << ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mio_responder.sv
// MIO bus responder: word RAM plus LED/switch IO window, programmable wait states.
// Optional MIO_BUS_ERR_EN adds bus_err for unmapped IO-window accesses.
module mio_responder
  import mio_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [3:0]  IO_HI       = 4'hE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        CPU_MIO,
  input  logic        mem_w,
  input  logic [31:0] Addr_in,
  input  logic [31:0] Data_from_cpu,
  output logic [31:0] Data_to_cpu,
  output logic        MIO_ready,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out,
  output logic        busy
`ifdef MIO_BUS_ERR_EN
  ,
  output logic        bus_err
`endif
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               accept;
  logic [31:2]        addr_q;
  logic               we_q;
  logic [31:0]        wdata_q;
  logic [31:0]        data_q;
  logic [31:0]        ram_q;
  logic [31:0]        rd_val;
  logic [ADDR_W-1:0]  ram_addr;
  logic               ram_we;
  logic               is_io;
  logic [27:0]        io_ofs;
  logic               led_hit;
  logic               sw_hit;
  logic               unused_addr_lsb;

  assign unused_addr_lsb = ^Addr_in[1:0];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    unique case (state)
      IDLE: if (CPU_MIO) begin
        accept    = 1'b1;
        cnt_nxt   = CNT_W'(WAIT_CYCLES);
        state_nxt = (WAIT_CYCLES == 0) ? ACK : WAIT;
      end
      WAIT: begin
        if (!CPU_MIO)        state_nxt = IDLE;
        else if (cnt == '0)  state_nxt = ACK;
        else                 cnt_nxt   = cnt - CNT_W'(1);
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign is_io   = (addr_q[31:28] == IO_HI);
  assign io_ofs  = {addr_q[27:2], 2'b00};
  assign led_hit = is_io && (io_ofs == LED_OFS);
  assign sw_hit  = is_io && (io_ofs == SW_OFS);

  // RAM is addressed from the live bus while idle so a zero-wait read has data ready in ACK.
  assign ram_addr = (state == IDLE) ? Addr_in[ADDR_W+1:2] : addr_q[ADDR_W+1:2];
  assign ram_we   = (state == ACK) && we_q && !is_io;

  mio_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_q)
  );

  always_comb begin
    rd_val = '0;
    if (!is_io)       rd_val = ram_q;
    else if (led_hit) rd_val = {16'h0000, led_out};
    else if (sw_hit)  rd_val = {16'h0000, sw_in};
  end

  assign MIO_ready   = (state == ACK);
  assign busy        = (state != IDLE);
  assign Data_to_cpu = ((state == ACK) && !we_q) ? rd_val : data_q;

`ifdef MIO_BUS_ERR_EN
  assign bus_err = (state == ACK) && is_io && !led_hit && !sw_hit;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      data_q  <= '0;
      led_out <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        addr_q  <= Addr_in[31:2];
        we_q    <= mem_w;
        wdata_q <= Data_from_cpu;
      end
      if (state == ACK) begin
        if (we_q) begin
          if (led_hit) led_out <= wdata_q[15:0];
        end else begin
          data_q <= rd_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_mio_responder.sv
// Randomised bench for mio_responder against a transaction-level model.
`timescale 1ns/1ps
module tb_mio_responder;

  localparam int unsigned WAIT_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        CPU_MIO = 1'b0;
  logic        mem_w = 1'b0;
  logic [31:0] Addr_in = '0;
  logic [31:0] Data_from_cpu = '0;
  logic [31:0] Data_to_cpu;
  logic        MIO_ready;
  logic [15:0] sw_in = '0;
  logic [15:0] led_out;
  logic        busy;
`ifdef MIO_BUS_ERR_EN
  logic        bus_err;
`endif

  always #5 clk = ~clk;

  mio_responder #(
    .ADDR_W      (10),
    .WAIT_CYCLES (WAIT_CYCLES),
    .IO_HI       (4'hE)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .CPU_MIO       (CPU_MIO),
    .mem_w         (mem_w),
    .Addr_in       (Addr_in),
    .Data_from_cpu (Data_from_cpu),
    .Data_to_cpu   (Data_to_cpu),
    .MIO_ready     (MIO_ready),
    .sw_in         (sw_in),
    .led_out       (led_out),
    .busy          (busy)
`ifdef MIO_BUS_ERR_EN
    ,
    .bus_err       (bus_err)
`endif
  );

  int vectors = 0;
  int errors  = 0;

  // Transaction-level model state
  logic [31:0] ram_m [int];
  logic [15:0] led_m      = '0;
  logic        exp_ready  = 1'b0;
  logic        exp_busy   = 1'b0;
  logic        exp_berr   = 1'b0;
  logic [31:0] exp_data   = '0;
  logic        data_known = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("ready", {31'b0, MIO_ready}, {31'b0, exp_ready});
      chk("busy", {31'b0, busy}, {31'b0, exp_busy});
      chk("led", {16'b0, led_out}, {16'b0, led_m});
      if (data_known) chk("rdata", Data_to_cpu, exp_data);
`ifdef MIO_BUS_ERR_EN
      chk("bus_err", {31'b0, bus_err}, {31'b0, exp_berr});
`endif
    end
  end

  // One request from an IDLE cycle; abort_at in 0..WAIT_CYCLES drops CPU_MIO in that wait cycle.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input int abort_at, output logic [31:0] got, output int lat);
    logic [31:0] rv;
    logic        rk;
    logic        io;
    logic [27:0] ofs;
    int          idx;
    int          c;
    io  = (a[31:28] == 4'hE);
    ofs = {a[27:2], 2'b00};
    idx = int'(a[11:2]);
    got = '0;
    lat = 0;
    c   = 0;
    CPU_MIO = 1'b1; mem_w = w; Addr_in = a; Data_from_cpu = d;
    exp_ready = 1'b0; exp_busy = 1'b0; exp_berr = 1'b0;
    step();
    exp_busy = 1'b1;
    for (int k = 0; k <= int'(WAIT_CYCLES); k++) begin
      mem_w = 1'($urandom); Addr_in = $urandom; Data_from_cpu = $urandom;
      if (k == abort_at) begin
        CPU_MIO = 1'b0;
        step();
        exp_busy = 1'b0;
        return;
      end
      step();
      c++;
      if (MIO_ready && lat == 0) lat = c;
    end
    exp_ready = 1'b1;
    if (io) exp_berr = (ofs != 28'h0) && (ofs != 28'h4);
    if (!w) begin
      rk = 1'b1;
      if (io) begin
        if (ofs == 28'h0)      rv = {16'h0, led_m};
        else if (ofs == 28'h4) rv = {16'h0, sw_in};
        else                   rv = '0;
      end else if (ram_m.exists(idx)) begin
        rv = ram_m[idx];
      end else begin
        rv = '0;
        rk = 1'b0;
      end
      exp_data   = rv;
      data_known = rk;
    end
    got = Data_to_cpu;
    step();
    if (w) begin
      if (!io)               ram_m[idx] = d;
      else if (ofs == 28'h0) led_m = d[15:0];
    end
    exp_ready = 1'b0; exp_busy = 1'b0; exp_berr = 1'b0;
  endtask

  task automatic idle(input int n);
    CPU_MIO = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 3) == 0) begin
      case ($urandom_range(0, 3))
        0:       a = 32'hE000_0000 | {30'b0, a[1:0]};
        1:       a = 32'hE000_0004 | {30'b0, a[1:0]};
        2:       a = 32'hE000_0100;
        default: a = {4'hE, a[27:0]};
      endcase
    end else begin
      if (a[31:28] == 4'hE) a[31:28] = 4'h0;
      a[11:2] = 10'($urandom_range(0, 15));
    end
    return a;
  endfunction

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] got;
    int          lat;
    #1 rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();

    txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, -1, got, lat);
    chk("pin_wr_latency", lat, 3);
    txn(1'b0, 32'h0000_0010, 32'h0, -1, got, lat);
    chk("pin_rd_latency", lat, 3);
    chk("pin_deadbeef", got, 32'hDEAD_BEEF);
    idle(1);

    txn(1'b1, 32'hE000_0000, 32'h0001_00A5, -1, got, lat);
    chk("pin_led", {16'b0, led_out}, 32'h0000_00A5);
    txn(1'b0, 32'hE000_0000, 32'h0, -1, got, lat);
    chk("pin_led_rd", got, 32'h0000_00A5);
    idle(2);

    sw_in = 16'h1234;
    txn(1'b0, 32'hE000_0004, 32'h0, -1, got, lat);
    chk("pin_sw_rd", got, 32'h0000_1234);
    txn(1'b1, 32'hE000_0004, 32'hFFFF_FFFF, -1, got, lat);
    chk("pin_sw_wr_led", {16'b0, led_out}, 32'h0000_00A5);
    idle(1);

    txn(1'b1, 32'h0000_0020, 32'h1111_1111, -1, got, lat);
    txn(1'b1, 32'h0000_0020, 32'h2222_2222, 1, got, lat);
    idle(2);
    txn(1'b0, 32'h0000_0020, 32'h0, -1, got, lat);
    chk("pin_abort", got, 32'h1111_1111);
    idle(1);

    txn(1'b1, 32'h0000_0030, 32'hCAFE_0030, -1, got, lat);
    CPU_MIO = 1'b1; mem_w = 1'b1; Addr_in = 32'h0000_0030; Data_from_cpu = 32'h5555_AAAA;
    step();
    exp_busy = 1'b1;
    step();
    rst_n = 1'b0;
    CPU_MIO = 1'b0;
    exp_busy = 1'b0; exp_ready = 1'b0; exp_berr = 1'b0;
    led_m = '0; exp_data = '0; data_known = 1'b1;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("pin_rst_led", {16'b0, led_out}, 32'h0);
    txn(1'b0, 32'h0000_0030, 32'h0, -1, got, lat);
    chk("pin_rst_nowrite", got, 32'hCAFE_0030);

`ifdef MIO_BUS_ERR_EN
    txn(1'b0, 32'hE000_0100, 32'h0, -1, got, lat);
    chk("pin_berr_data", got, 32'h0);
`endif
    idle(1);

    for (int n = 0; n < 400; n++) begin
      int ab;
      sw_in = 16'($urandom);
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, WAIT_CYCLES)) : -1;
      txn(1'($urandom), rand_addr(), $urandom, ab, got, lat);
      if (ab < 0) chk("rand_latency", lat, WAIT_CYCLES + 1);
      if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 2)));
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
